// File: rtl/deserializer_pkg.sv
// ---------------------------------------------------------------------------
// deserializer_pkg
// Shared definitions for the SPI frame deserializer: default field widths,
// the full on-wire frame width (start bit + opcode + address), the FSM
// state encoding and a constant-evaluable clog2 helper used to size the
// bit counter.
// ---------------------------------------------------------------------------
package deserializer_pkg;

    localparam int DEF_OPW   = 2;
    localparam int DEF_ADDRW = 24;

    // Number of bits on the wire for one frame: start bit + opcode + address.
    function automatic int frameWidth(input int opw, input int addrw);
        return 1 + opw + addrw;
    endfunction

    localparam int FRAME_W = frameWidth(DEF_OPW, DEF_ADDRW);

    // Ceiling log2; clog2(n) is the number of bits needed to count 0..n-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing one asynchronous input into the clk domain.
// RESET_VAL sets the value both flops take while rst_n is low, so that an
// inactive level (e.g. chip select deasserted) is presented during reset.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   i_d    asynchronous input
//   o_q    synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
// Oversampling SPI receiver. spi_clk, n_cs and mosi are synchronized into
// the clk domain; mosi is captured on each detected spi_clk rising edge.
// A frame is [start=1][opcode MSB-first][addr MSB-first]. Leading zeros are
// skipped while hunting for the start bit, and after a complete frame the
// receiver hunts again so frames may follow back-to-back under one n_cs low.
// The finished word is presented with a valid/ready handshake; a frame that
// completes while a word is still held and not being accepted is dropped.
//
// Ports:
//   clk        system clock (>= 4x spi_clk)
//   rst_n      asynchronous active-low reset
//   n_cs       SPI chip select, active low (asynchronous)
//   spi_clk    SPI clock (asynchronous), mosi sampled on its rising edge
//   mosi       SPI serial data (asynchronous)
//   ready_in   downstream accepts the word while valid_out is high
//   valid_out  opcode/addr hold a complete frame
//   opcode     received opcode, stable while valid_out is high
//   addr       received address, stable while valid_out is high
//   err        one-cycle pulse on an aborted or dropped frame
// ---------------------------------------------------------------------------
module deserializer
    import deserializer_pkg::*;
#(
    parameter int ADDRW = DEF_ADDRW,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             n_cs,
    input  logic             spi_clk,
    input  logic             mosi,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [OPW-1:0]   opcode,
    output logic [ADDRW-1:0] addr,
    output logic             err
);

    // Payload bits after the start bit.
    localparam int PAY_W = frameWidth(OPW, ADDRW) - 1;
    localparam int CNT_W = clog2(PAY_W + 1);

    logic             w_spiClk;
    logic             w_nCs;
    logic             w_mosi;
    logic             w_rise;
    logic             w_accept;
    logic [PAY_W-1:0] w_nextShift;

    logic             r_spiClkPrev;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [PAY_W-1:0] r_shiftReg;

    sync2 #(.RESET_VAL(1'b0)) u_syncSpiClk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (spi_clk),
        .o_q   (w_spiClk)
    );

    sync2 #(.RESET_VAL(1'b1)) u_syncNCs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (n_cs),
        .o_q   (w_nCs)
    );

    sync2 #(.RESET_VAL(1'b0)) u_syncMosi (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (mosi),
        .o_q   (w_mosi)
    );

    // Remember last cycle's synchronized spi_clk so a 0->1 step can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spiClkPrev <= 1'b0;
        end else begin
            r_spiClkPrev <= w_spiClk;
        end
    end

    assign w_rise      = w_spiClk & ~r_spiClkPrev;
    assign w_accept    = valid_out & ready_in;
    // The shift register as it will look once the current sample is shifted in;
    // on the final bit this is the complete payload.
    assign w_nextShift = {r_shiftReg[PAY_W-2:0], w_mosi};

    // Frame FSM together with the registered handshake outputs. An accept
    // clears valid_out by default; a frame completing in the same cycle
    // overrides that and keeps valid_out high with the new word. Completion
    // is recognised on the bit that takes the counter from 1 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_shiftReg <= '0;
            valid_out  <= 1'b0;
            opcode     <= '0;
            addr       <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (w_accept) begin
                valid_out <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_nCs) begin
                        r_state <= ST_HUNT;
                    end
                end

                ST_HUNT: begin
                    if (w_nCs) begin
                        r_state <= ST_IDLE;
                    end else if (w_rise && w_mosi) begin
                        r_shiftReg <= '0;
                        r_count    <= CNT_W'(PAY_W);
                        r_state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_nCs) begin
                        err     <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_rise) begin
                        r_shiftReg <= w_nextShift;
                        r_count    <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state <= ST_HUNT;
                            if (!valid_out || w_accept) begin
                                opcode    <= w_nextShift[PAY_W-1 -: OPW];
                                addr      <= w_nextShift[ADDRW-1:0];
                                valid_out <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
// Self-checking bench for the SPI deserializer. A table of frames is applied
// first, then hand-written sequences for abort, drop, back-to-back and
// mid-frame reset, then randomized frames against a word-level model that
// tracks only "is a word held, which one, and how many err pulses are due".
// ---------------------------------------------------------------------------
module tb_deserializer;
    import deserializer_pkg::*;

    localparam int ADDRW = 24;
    localparam int OPW   = 2;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             n_cs     = 1'b1;
    logic             spi_clk  = 1'b0;
    logic             mosi     = 1'b0;
    logic             ready_in = 1'b0;
    logic             valid_out;
    logic [OPW-1:0]   opcode;
    logic [ADDRW-1:0] addr;
    logic             err;

    int checks      = 0;
    int errors      = 0;
    int errSeen     = 0;
    int errExp      = 0;
    int validCycles = 0;

    logic [OPW+ADDRW-1:0] capQ[$];

    logic                 mValid = 1'b0;
    logic [OPW+ADDRW-1:0] mWord  = '0;

    typedef struct {
        logic [OPW-1:0]   op;
        logic [ADDRW-1:0] addr;
        int               lead;
        logic [OPW-1:0]   expOp;
        logic [ADDRW-1:0] expAddr;
    } vec_t;

    vec_t vecs[5];

    deserializer #(.ADDRW(ADDRW), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .n_cs      (n_cs),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .opcode    (opcode),
        .addr      (addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Observe the DUT on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (err) errSeen++;
        if (valid_out) validCycles++;
        if (valid_out && ready_in) capQ.push_back({opcode, addr});
    end

    // Advance n clocks; inputs are then changed 2 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One SPI bit: data set up, spi_clk high for 4 clocks, low for 4 clocks.
    task automatic sendBit(input logic b);
        mosi = b;
        tick(4);
        spi_clk = 1'b1;
        tick(4);
        spi_clk = 1'b0;
    endtask

    // Send a frame with optional leading zeros. If abortAfter is in range,
    // n_cs is raised after the start bit plus that many payload bits.
    task automatic sendFrame(input logic [OPW-1:0] op, input logic [ADDRW-1:0] a,
                             input int lead, input int abortAfter);
        logic [OPW+ADDRW-1:0] w;
        w    = {op, a};
        n_cs = 1'b0;
        tick(4);
        repeat (lead) sendBit(1'b0);
        sendBit(1'b1);
        for (int i = 0; i < OPW + ADDRW; i++) begin
            if (i == abortAfter) begin
                n_cs = 1'b1;
                tick(6);
                return;
            end
            sendBit(w[OPW+ADDRW-1-i]);
        end
    endtask

    task automatic endFrame();
        n_cs = 1'b1;
        tick(4);
    endtask

    task automatic acceptWord();
        ready_in = 1'b1;
        tick(1);
        ready_in = 1'b0;
        tick(1);
    endtask

    // Hand off the held word (if any) and confirm the handshake carried it.
    task automatic acceptAndCheck();
        if (mValid) begin
            capQ.delete();
            acceptWord();
            checkOutput("accept count", capQ.size(), 1);
            if (capQ.size() > 0) checkOutput("accept word", 32'(capQ[0]), 32'(mWord));
            checkOutput("valid after accept", 32'(valid_out), 0);
            mValid = 1'b0;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " valid"}, 32'(valid_out), 32'(mValid));
        if (mValid) begin
            checkOutput({tag, " opcode"}, 32'(opcode), 32'(mWord[OPW+ADDRW-1 -: OPW]));
            checkOutput({tag, " addr"}, 32'(addr), 32'(mWord[ADDRW-1:0]));
        end
        checkOutput({tag, " errcount"}, errSeen, errExp);
    endtask

    task automatic applyStimulus(input vec_t v);
        acceptAndCheck();
        sendFrame(v.op, v.addr, v.lead, -1);
        endFrame();
        mValid = 1'b1;
        mWord  = {v.expOp, v.expAddr};
        checkOutput("vec valid", 32'(valid_out), 1);
        checkOutput("vec opcode", 32'(opcode), 32'(v.expOp));
        checkOutput("vec addr", 32'(addr), 32'(v.expAddr));
        checkOutput("vec errcount", errSeen, errExp);
    endtask

    initial begin
        logic [FRAME_W-1:0]   ignored;
        logic [OPW-1:0]       rOp;
        logic [ADDRW-1:0]     rAddr;
        int                   vc0;
        int                   abortAt;

        vecs[0] = '{2'b10, 24'hA5C3F0, 0, 2'b10, 24'hA5C3F0};
        vecs[1] = '{2'b10, 24'hA5C3F0, 3, 2'b10, 24'hA5C3F0};
        vecs[2] = '{2'b01, 24'h000001, 1, 2'b01, 24'h000001};
        vecs[3] = '{2'b11, 24'hFFFFFF, 2, 2'b11, 24'hFFFFFF};
        vecs[4] = '{2'b00, 24'h800000, 0, 2'b00, 24'h800000};

        // Reset state.
        tick(3);
        checkOutput("reset valid", 32'(valid_out), 0);
        checkOutput("reset opcode", 32'(opcode), 0);
        checkOutput("reset addr", 32'(addr), 0);
        checkOutput("reset err", 32'(err), 0);
        rst_n = 1'b1;
        tick(2);

        // Table-driven frames, including leading zeros before the start bit.
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Abort after start bit plus 10 bits.
        acceptAndCheck();
        sendFrame(2'b10, 24'hA5C3F0, 0, 10);
        errExp++;
        checkModel("abort");

        // spi_clk activity with n_cs high must be ignored.
        ignored = {1'b1, 2'b10, 24'hA5C3F0};
        for (int i = FRAME_W - 1; i >= 0; i--) sendBit(ignored[i]);
        tick(4);
        checkModel("idle ignore");

        // Second frame completes while the first is held: dropped with err.
        sendFrame(2'b01, 24'h000001, 0, -1);
        sendFrame(2'b11, 24'hFFFFFF, 0, -1);
        endFrame();
        errExp++;
        mValid = 1'b1;
        mWord  = {2'b01, 24'h000001};
        checkModel("drop");

        // Back-to-back frames with ready tied high.
        acceptAndCheck();
        capQ.delete();
        vc0      = validCycles;
        ready_in = 1'b1;
        sendFrame(2'b10, 24'h123456, 0, -1);
        sendFrame(2'b01, 24'hABCDEF, 0, -1);
        endFrame();
        ready_in = 1'b0;
        tick(2);
        checkOutput("b2b count", capQ.size(), 2);
        if (capQ.size() == 2) begin
            checkOutput("b2b word0", 32'(capQ[0]), 32'({2'b10, 24'h123456}));
            checkOutput("b2b word1", 32'(capQ[1]), 32'({2'b01, 24'hABCDEF}));
        end
        checkOutput("b2b valid cycles", validCycles - vc0, 2);
        checkModel("b2b");

        // Reset in the middle of a frame while a word is held.
        sendFrame(2'b11, 24'h654321, 0, -1);
        mValid = 1'b1;
        mWord  = {2'b11, 24'h654321};
        checkModel("pre-reset");
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        rst_n = 1'b0;
        #3;
        checkOutput("midreset valid", 32'(valid_out), 0);
        checkOutput("midreset opcode", 32'(opcode), 0);
        checkOutput("midreset addr", 32'(addr), 0);
        checkOutput("midreset err", 32'(err), 0);
        tick(3);
        rst_n  = 1'b1;
        mValid = 1'b0;
        tick(2);
        sendFrame(2'b01, 24'h3C5A96, 1, -1);
        endFrame();
        mValid = 1'b1;
        mWord  = {2'b01, 24'h3C5A96};
        checkModel("post-reset");

        // Randomized frames against the word-level model.
        for (int n = 0; n < 40; n++) begin
            rOp   = OPW'($urandom_range(0, 3));
            rAddr = ADDRW'($urandom);
            if (mValid && ($urandom_range(0, 1) == 1)) acceptAndCheck();
            abortAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, OPW + ADDRW - 1)) : -1;
            sendFrame(rOp, rAddr, int'($urandom_range(0, 3)), abortAt);
            endFrame();
            if (abortAt >= 0) begin
                errExp++;
            end else if (!mValid) begin
                mValid = 1'b1;
                mWord  = {rOp, rAddr};
            end else begin
                errExp++;
            end
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter ADDRW, default 24, sets the address field width in bits.
REQ-002 Parameter OPW, default 2, sets the opcode field width in bits.
REQ-003 clk  input  1  system clock; single clock domain; fclk >= 4x fspi_clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 n_cs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 spi_clk  input  1  SPI clock, asynchronous to clk; mosi is sampled on its rising edge.
REQ-007 mosi  input  1  serial data; frame = [start=1][opcode MSB-first][addr MSB-first].
REQ-008 ready_in  input  1  downstream accepts the word when high with valid_out high.
REQ-009 valid_out  output  1  opcode/addr hold a complete frame.
REQ-010 opcode  output  OPW  received opcode; stable while valid_out is high.
REQ-011 addr  output  ADDRW  received address; stable while valid_out is high.
REQ-012 err  output  1  one-cycle pulse on an aborted or dropped frame.

Function
REQ-013 spi_clk, n_cs and mosi SHALL each pass through a 2-flop synchronizer; a rising edge SHALL be detected as synchronized spi_clk going 0->1 across consecutive clk cycles.
REQ-014 mosi SHALL be sampled from its synchronized copy in the cycle the rising edge is detected.
REQ-015 FSM states: IDLE, HUNT, SHIFT.
REQ-016 IDLE: synchronized n_cs high; a synchronized n_cs low SHALL move to HUNT.
REQ-017 HUNT: sampled 0 bits SHALL be discarded; a sampled 1 SHALL be taken as the start bit, clear the shift register, load the bit counter with OPW+ADDRW, and move to SHIFT.
REQ-018 SHIFT: each sampled bit SHALL left-shift into an (OPW+ADDRW)-bit register and decrement the counter.
REQ-019 When the counter reaches 0, the frame SHALL be complete and the FSM SHALL return to HUNT, enabling back-to-back frames without n_cs toggling.
REQ-020 On completion with valid_out low, opcode/addr SHALL load from the register's top OPW and low ADDRW bits; valid_out SHALL rise on the next clk edge.
REQ-021 On completion with valid_out high and ready_in low in that cycle, the frame SHALL be dropped and err SHALL pulse; held outputs SHALL not change.
REQ-022 On completion in the same cycle as a valid_out&&ready_in accept, the new frame SHALL load; valid_out SHALL stay high; no err.
REQ-023 valid_out SHALL fall on the cycle after valid_out&&ready_in unless REQ-022 applies.
REQ-024 Synchronized n_cs high in SHIFT SHALL abort the frame, pulse err for one cycle, and return to IDLE; partial data SHALL never reach opcode/addr.
REQ-025 n_cs high in HUNT or IDLE SHALL go to IDLE with no err.
REQ-026 Rising spi_clk edges while in IDLE SHALL be ignored.
REQ-027 The counter width SHALL be clog2(OPW+ADDRW+1).

Reset
REQ-028 rst_n low SHALL force: FSM to IDLE; counter to 0; shift register to 0; valid_out 0; opcode 0; addr 0; err 0.
REQ-029 Synchronizer flops SHALL reset to n_cs=1, spi_clk=0, mosi=0.
REQ-030 Reset mid-frame SHALL discard the frame without an err pulse.

Structure
REQ-031 The shared package SHALL hold the clog2 function, the FRAME_W = 1+OPW+ADDRW constant, and the FSM state encoding.
REQ-032 One sub-module, sync2 (2-flop synchronizer, parameterized reset value), SHALL be instantiated three times.

Verification
REQ-033 ADDRW=24, OPW=2: n_cs low, send 1,2'b10,24'hA5C3F0 -> valid_out=1, opcode=2'b10, addr=24'hA5C3F0, err=0.
REQ-034 Three leading 0s, then the frame from REQ-033 -> identical result; leading zeros ignored.
REQ-035 n_cs rises after the start bit plus 10 bits -> one err pulse; valid_out stays 0; FSM in IDLE.
REQ-036 ready_in=0; send two frames (2'b01,24'h000001 then 2'b11,24'hFFFFFF) -> outputs hold the first; one err pulse at the second's completion.
REQ-037 ready_in=1 tied; back-to-back frames under one n_cs low -> two single-cycle valid_out pulses with the correct values; no err.
REQ-038 rst_n asserted mid-SHIFT -> all outputs 0 within one cycle; the next full frame is received correctly.
